// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and reset-cause codes for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SW_ASSERT = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

endpackage

// File: rtl/rst_sync_2ff.sv
// rtl/rst_sync_2ff.sv - two-flop reset synchronizer: asynchronous assert, release on the 2nd clean edge
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_i,
  output logic rst_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset release with software restart; watchdog restart under RST_SEQ_WDT_EN
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DLY   = 16,
  parameter int SW_RST_LEN  = 8,
  parameter int CNT_W       = 8,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
`ifdef RST_SEQ_WDT_EN
  input  logic                  wdt_kick,
`endif
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  busy,
  output logic [1:0]            rst_cause
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SW_TC    = CNT_W'(SW_RST_LEN - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_DLY < 1 || SW_RST_LEN < 1 || WDT_TIMEOUT < 2) begin : g_bad_params
    $error("rst_sequencer: parameter out of range");
  end

  logic rst_int;

  rst_sync_2ff u_rst_sync (
    .clk   (clk),
    .rst_i (rst),
    .rst_o (rst_int)
  );

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_STAGES-1:0]  stage_q;
  logic                   done_q;
  logic [1:0]             cause_q;
  logic                   sw_req_ok;
  logic                   restart;
  logic [1:0]             restart_cause;

  assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign sw_req_ok = sw_rst_req && (state_q == RUN || state_q == RELEASE);

`ifdef RST_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_TIMEOUT + 1);

  logic [WDT_W-1:0] wdt_q;
  logic             wdt_expired;

  assign wdt_expired   = (state_q == RUN) && (wdt_q == WDT_W'(WDT_TIMEOUT - 1)) && !wdt_kick;
  assign restart       = sw_req_ok || wdt_expired;
  // A coincident software request takes precedence in the reported cause.
  assign restart_cause = sw_req_ok ? CAUSE_SW : CAUSE_WDT;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      wdt_q <= '0;
    end else if (state_q != RUN || wdt_kick || restart) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_q + 1'b1;
    end
  end
`else
  assign restart       = sw_req_ok;
  assign restart_cause = CAUSE_SW;
`endif

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else if (restart) begin
      state_q <= SW_ASSERT;
      cnt_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
      cause_q <= restart_cause;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == STAGE_TC) begin
            cnt_q      <= '0;
            stage_q[0] <= 1'b0;
            if (NUM_STAGES == 1) begin
              done_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              idx_q   <= IDX_W'(1);
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE: begin
          if (cnt_q == STAGE_TC) begin
            cnt_q   <= '0;
            stage_q <= stage_q & ~(NUM_STAGES'(1) << idx_q);
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              done_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        SW_ASSERT: begin
          if (cnt_q == SW_TC) begin
            cnt_q   <= '0;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= HOLD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stage_rst = stage_q;
  assign seq_done  = done_q;
  assign busy      = ~done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench: three sequencer configurations against a release-time model
module tb_rst_sequencer;

  localparam int ND    = 3;
  localparam int WDT_T = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic [2:0] st0;
  logic [0:0] st1;
  logic [7:0] st2;
  logic [ND-1:0] done_o;
  logic [ND-1:0] busy_o;
  logic [1:0] cause0, cause1, cause2;

  rst_sequencer #(.NUM_STAGES(3), .STAGE_DLY(16), .SW_RST_LEN(8), .CNT_W(8), .WDT_TIMEOUT(WDT_T)) dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
`endif
    .stage_rst(st0), .seq_done(done_o[0]), .busy(busy_o[0]), .rst_cause(cause0));

  rst_sequencer #(.NUM_STAGES(1), .STAGE_DLY(1), .SW_RST_LEN(8), .CNT_W(8), .WDT_TIMEOUT(WDT_T)) dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
`endif
    .stage_rst(st1), .seq_done(done_o[1]), .busy(busy_o[1]), .rst_cause(cause1));

  rst_sequencer #(.NUM_STAGES(8), .STAGE_DLY(3), .SW_RST_LEN(5), .CNT_W(8), .WDT_TIMEOUT(WDT_T)) dut2 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
`endif
    .stage_rst(st2), .seq_done(done_o[2]), .busy(busy_o[2]), .rst_cause(cause2));

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0][7:0] stage;
    logic [ND-1:0]      done;
    logic [ND-1:0][1:0] cause;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         c;
  int         a[ND];
  int         w[ND];
  logic [1:0] mc[ND];
  bit         phase_a;
  bit         dir_en;

  function automatic int nstg(int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 8;
  endfunction
  function automatic int dly(int i);
    return (i == 0) ? 16 : (i == 1) ? 1 : 3;
  endfunction
  function automatic int len(int i);
    return (i == 2) ? 5 : 8;
  endfunction

  // Stage k of a sequence anchored at cycle a is released from cycle a+(k+1)*delay on.
  function automatic logic [7:0] m_stage(int i, int cyc);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < nstg(i); k++)
      if (cyc < a[i] + (k + 1) * dly(i)) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic m_done(int i, int cyc);
    return cyc >= a[i] + nstg(i) * dly(i);
  endfunction

  function automatic logic [7:0] act_stage(int i);
    return (i == 0) ? {5'b0, st0} : (i == 1) ? {7'b0, st1} : st2;
  endfunction
  function automatic logic [1:0] act_cause(int i);
    return (i == 0) ? cause0 : (i == 1) ? cause1 : cause2;
  endfunction

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, c, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < ND; i++) begin
      a[i]  = 2;
      w[i]  = 0;
      mc[i] = 2'b01;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      e.stage[i] = m_stage(i, c);
      e.done[i]  = m_done(i, c);
      e.cause[i] = mc[i];
    end
    q.push_back(e);
  endtask

  // Constant expectations for the directed timing points of the default and minimal configurations.
  task automatic directed();
    if (dir_en) begin
      case (c)
        17: chk("por_hold_17", 0, act_stage(0), 8'h07);
        18: chk("por_stage0_18", 0, act_stage(0), 8'h06);
        33: chk("por_stage0_33", 0, act_stage(0), 8'h06);
        34: chk("por_stage1_34", 0, act_stage(0), 8'h04);
        49: chk("por_done_49", 0, {7'b0, done_o[0]}, 8'h00);
        50: begin
          chk("por_stage2_50", 0, act_stage(0), 8'h00);
          chk("por_done_50", 0, {7'b0, done_o[0]}, 8'h01);
          chk("por_cause_50", 0, {6'b0, cause0}, 8'h01);
        end
        2: chk("min_done_2", 1, {7'b0, done_o[1]}, 8'h00);
        3: begin
          chk("min_stage_3", 1, act_stage(1), 8'h00);
          chk("min_done_3", 1, {7'b0, done_o[1]}, 8'h01);
        end
        default: ;
      endcase
      if (phase_a) begin
        case (c)
          100: chk("run_100", 0, act_stage(0), 8'h00);
          101: begin
            chk("sw_assert_101", 0, act_stage(0), 8'h07);
            chk("sw_cause_101", 0, {6'b0, cause0}, 8'h02);
          end
          109: chk("sw_hold_109", 0, act_stage(0), 8'h07);
          124: chk("sw_hold_124", 0, act_stage(0), 8'h07);
          125: chk("sw_stage0_125", 0, act_stage(0), 8'h06);
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input logic r, input logic sw, input logic k);
    logic       pre_run;
    logic       tsw;
    logic       twdt;
    logic [7:0] s0;
    @(negedge clk);
    directed();
    rst = r;
    sw_rst_req = sw;
    wdt_kick = k;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < ND; i++) begin
        pre_run = m_done(i, c);
        s0      = m_stage(i, c);
        tsw     = sw && !s0[0];
        twdt    = 1'b0;
`ifdef RST_SEQ_WDT_EN
        twdt    = pre_run && (w[i] == WDT_T - 1) && !k;
`endif
        if (tsw || twdt) begin
          a[i]  = c + 1 + len(i);
          mc[i] = tsw ? 2'b10 : 2'b11;
          w[i]  = 0;
        end else begin
          w[i] = (pre_run && !k) ? w[i] + 1 : 0;
        end
      end
      c++;
    end
    push_exp();
  endtask

  task automatic async_rst();
    @(negedge clk);
    directed();
    sw_rst_req = 1'b0;
    wdt_kick = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_stage", 0, act_stage(0), 8'h07);
    chk("async_stage", 1, act_stage(1), 8'h01);
    chk("async_stage", 2, act_stage(2), 8'hff);
    chk("async_done", 0, {7'b0, done_o[0]}, 8'h00);
    chk("async_cause", 0, {6'b0, cause0}, 8'h01);
    model_reset();
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < ND; i++) begin
          chk("sb_stage", i, act_stage(i), e.stage[i]);
          chk("sb_done", i, {7'b0, done_o[i]}, {7'b0, e.done[i]});
          chk("sb_busy", i, {7'b0, busy_o[i]}, {7'b0, ~e.done[i]});
          chk("sb_cause", i, {6'b0, act_cause(i)}, {6'b0, e.cause[i]});
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    dir_en  = 1'b1;
    phase_a = 1'b1;
    for (int n = 0; n < 5; n++) step(1'b1, $urandom_range(0, 1) == 1, 1'b0);
    for (int n = 0; n < 140; n++) step(1'b0, c == 10 || c == 100 || c == 103, (n % 20) == 19);
    phase_a = 1'b0;
    async_rst();
    for (int n = 0; n < 3; n++) step(1'b1, $urandom_range(0, 1) == 1, 1'b0);
    for (int n = 0; n < 300; n++) step(1'b0, c > 60 && $urandom_range(0, 39) == 0, (n % 20) == 19);
    dir_en = 1'b0;
    for (int n = 0; n < 500; n++) step(1'b0, 1'b0, (n % 20) == 19);
    for (int n = 0; n < 100; n++) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_drained", 0, 8'(q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
